// File: rtl/score_pkg.sv
// Shared constants, FSM/branch enums and width helper for the score engine.
package score_pkg;

  localparam int unsigned DEF_GRACE       = 60;
  localparam int unsigned DEF_TIME_LIMIT  = 600;
  localparam int unsigned DEF_MAX_SCORE   = 100;
  localparam int unsigned DEF_ERR_PENALTY = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    APPLY  = 2'd2
  } state_e;

  // How the time component of the score is formed for the captured timer value.
  typedef enum logic [1:0] {
    BR_DIV  = 2'd0,
    BR_MAX  = 2'd1,
    BR_ZERO = 2'd2
  } branch_e;

  function automatic int unsigned num_width(input int unsigned timer_w,
                                            input int unsigned score_w);
    return timer_w + score_w;
  endfunction

endpackage

// File: rtl/score_engine_seq_divider.sv
// Unsigned restoring divider, one quotient bit per edge MSB first, W edges per
// division. The first bit is taken on the start edge; done_o pulses with quotient_o valid.
module seq_divider #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         abort_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     rem_q, quot_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  logic [W-1:0] rem_src, quot_src, dvs_src, rem_d, quot_d;
  logic [W:0]   shifted;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    rem_src  = start_i ? '0         : rem_q;
    quot_src = start_i ? dividend_i : quot_q;
    dvs_src  = start_i ? divisor_i  : dvs_q;
    shifted  = {rem_src, quot_src[W-1]};
    if (shifted >= {1'b0, dvs_src}) begin
      rem_d  = W'(shifted - {1'b0, dvs_src});
      quot_d = {quot_src[W-2:0], 1'b1};
    end else begin
      rem_d  = shifted[W-1:0];
      quot_d = {quot_src[W-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= divisor_i;
      cnt_q  <= CNT_W'(W - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quot_q;

endmodule

// File: rtl/score_engine.sv
// Game scorer: time score via a sequential divider minus a mistake penalty.
// Define SCORE_BEST_EN to build best-score tracking; otherwise best_score is 0.
module score_engine
  import score_pkg::*;
#(
  parameter int unsigned TIMER_W     = 11,
  parameter int unsigned SCORE_W     = 7,
  parameter int unsigned ERR_W       = 4,
  parameter int unsigned GRACE       = DEF_GRACE,
  parameter int unsigned TIME_LIMIT  = DEF_TIME_LIMIT,
  parameter int unsigned MAX_SCORE   = DEF_MAX_SCORE,
  parameter int unsigned ERR_PENALTY = DEF_ERR_PENALTY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               calc_req,
  input  logic               clear,
  input  logic [TIMER_W-1:0] timer,
  input  logic [ERR_W-1:0]   errors,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score
);

  localparam int unsigned NUM_W = num_width(TIMER_W, SCORE_W);
  localparam logic [TIMER_W-1:0] GRACE_T = TIMER_W'(GRACE);
  localparam logic [TIMER_W-1:0] LIMIT_T = TIMER_W'(TIME_LIMIT);

  state_e             state_q;
  branch_e            branch_q;
  logic [ERR_W-1:0]   errors_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               busy_q, done_q;

  logic             div_start, div_done;
  logic [NUM_W-1:0] numerator, quotient, base_full, penalty;

  assign div_start = (state_q == IDLE) && calc_req && !clear;
  // The divider runs on every request so latency never depends on the branch;
  // its quotient is only consumed on the divide branch.
  assign numerator = NUM_W'(timer - GRACE_T) * NUM_W'(MAX_SCORE);

  seq_divider #(.W(NUM_W)) u_div (
    .clk        (clk),
    .reset      (reset),
    .abort_i    (clear),
    .start_i    (div_start),
    .dividend_i (numerator),
    .divisor_i  (NUM_W'(TIME_LIMIT - GRACE)),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_comb begin
    case (branch_q)
      BR_MAX:  base_full = NUM_W'(MAX_SCORE);
      BR_ZERO: base_full = '0;
      default: base_full = NUM_W'(MAX_SCORE) - quotient;
    endcase
    penalty = NUM_W'(errors_q) * NUM_W'(ERR_PENALTY);
    score_d = (base_full > penalty) ? SCORE_W'(base_full - penalty) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      branch_q <= BR_DIV;
      errors_q <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      score_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (calc_req) begin
          errors_q <= errors;
          if (timer <= GRACE_T)      branch_q <= BR_MAX;
          else if (timer >= LIMIT_T) branch_q <= BR_ZERO;
          else                       branch_q <= BR_DIV;
          busy_q  <= 1'b1;
          state_q <= DIVIDE;
        end
        DIVIDE: if (div_done) state_q <= APPLY;
        APPLY: begin
          score_q <= score_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign score = score_q;

`ifdef SCORE_BEST_EN
  logic [SCORE_W-1:0] best_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_q <= '0;
    end else if (!clear && (state_q == APPLY) && (score_d > best_q)) begin
      best_q <= score_d;
    end
  end

  assign best_score = best_q;
`else
  assign best_score = '0;
`endif

endmodule

// File: tb/tb_score_engine.sv
// Directed, table-driven bench for score_engine (default parameters).
module tb_score_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        calc_req;
  logic        clear;
  logic [10:0] timer;
  logic [3:0]  errors;
  logic        busy, done;
  logic [6:0]  score, best_score;

  int n_vec = 0;
  int n_err = 0;
  int best_m = 0;

  typedef struct {
    int timer;
    int errors;
    int exp_score;
  } vec_t;

  vec_t vecs[9];

  score_engine dut (
    .clk        (clk),
    .reset      (reset),
    .calc_req   (calc_req),
    .clear      (clear),
    .timer      (timer),
    .errors     (errors),
    .busy       (busy),
    .done       (done),
    .score      (score),
    .best_score (best_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic update_best(input int s);
`ifdef SCORE_BEST_EN
    if (s > best_m) best_m = s;
`else
    best_m = 0;
`endif
  endtask

  // Issues one request, returns busy right after acceptance and edges to done (-1 on timeout).
  task automatic do_calc(input int t, input int e, output logic busy_acc, output int lat);
    @(negedge clk);
    calc_req = 1'b1;
    timer    = 11'(t);
    errors   = 4'(e);
    @(posedge clk); #1;
    busy_acc = busy;
    lat = -1;
    @(negedge clk);
    calc_req = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_req(input int t, input int e);
    @(negedge clk);
    calc_req = 1'b1;
    timer    = 11'(t);
    errors   = 4'(e);
    @(negedge clk);
    calc_req = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  task automatic run_vec(input string tag, input int t, input int e, input int exp_s);
    logic busy_acc;
    int   lat;
    do_calc(t, e, busy_acc, lat);
    update_best(exp_s);
    check({tag, " busy"}, 32'(busy_acc), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd19);
    check({tag, " score"}, 32'(score), 32'(exp_s));
    check({tag, " best"}, 32'(best_score), 32'(best_m));
    @(posedge clk); #1;
    check({tag, " done width"}, 32'(done), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int held;

    vecs[0] = '{30,   0,  100};
    vecs[1] = '{60,   0,  100};
    vecs[2] = '{330,  0,  50};
    vecs[3] = '{330,  3,  35};
    vecs[4] = '{61,   0,  100};
    vecs[5] = '{599,  0,  1};
    vecs[6] = '{599,  1,  0};
    vecs[7] = '{600,  0,  0};
    vecs[8] = '{2047, 15, 0};

    reset = 1'b1; calc_req = 1'b0; clear = 1'b0; timer = '0; errors = '0;
    #12;
    check("reset score", 32'(score), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset best", 32'(best_score), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d t=%0d e=%0d", i, vecs[i].timer, vecs[i].errors),
              vecs[i].timer, vecs[i].errors, vecs[i].exp_score);
    end

    // Score holds while idle; seed a nonzero value first.
    run_vec("hold seed", 330, 0, 50);
    held = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) held++;
    end
    check("hold score", 32'(score), 32'd50);
    check("hold no done", 32'(held), 32'd0);

    // Second request while busy is dropped.
    pulse_req(599, 0);
    repeat (4) @(negedge clk);
    pulse_req(30, 0);
    count_dones(60, n);
    update_best(1);
    check("busy-ignore done count", 32'(n), 32'd1);
    check("busy-ignore score", 32'(score), 32'd1);

    // Clear mid-divide aborts with no done.
    run_vec("clear seed", 330, 0, 50);
    pulse_req(30, 0);
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    check("clear score", 32'(score), 32'd0);
    check("clear busy", 32'(busy), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    count_dones(40, n);
    check("clear no done", 32'(n), 32'd0);
    check("clear best kept", 32'(best_score), 32'(best_m));

    // clear and calc_req together: request dropped.
    @(negedge clk);
    calc_req = 1'b1; clear = 1'b1; timer = 11'd30; errors = '0;
    @(posedge clk); #1;
    check("clear+req busy", 32'(busy), 32'd0);
    @(negedge clk);
    calc_req = 1'b0; clear = 1'b0;
    count_dones(30, n);
    check("clear+req no done", 32'(n), 32'd0);
    check("clear+req score", 32'(score), 32'd0);

    // Reset mid-divide zeroes every output at once.
    run_vec("reset seed", 30, 0, 100);
    pulse_req(330, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset score", 32'(score), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset best", 32'(best_score), 32'd0);
    best_m = 0;
    @(negedge clk);
    reset = 1'b0;

    // Best-score sequence 50, 100, 35.
    run_vec("best 50", 330, 0, 50);
    run_vec("best 100", 30, 0, 100);
    run_vec("best 35", 330, 3, 35);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("best after clear", 32'(best_score), 32'(best_m));
    reset = 1'b1;
    #1;
    check("best after reset", 32'(best_score), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_engine.md
Name: score_engine

Overview:
- Parametrised successor to the game's fixed 60 s / 600 s / 100-point scorer.
- Computes a game score from elapsed time and mistake count on request, using an iterative restoring divider (one quotient bit per cycle) instead of a combinational divide.
- Sits between the game controller (issues calc_req at puzzle completion) and the display/score path (consumes score on done).
- Adds a mistake penalty, a request/done handshake, a synchronous clear, and optional best-score tracking.

Parameters:
- TIMER_W, 11, width of timer input (seconds).
- SCORE_W, 7, width of score outputs.
- ERR_W, 4, width of mistake counter input.
- GRACE, 60, timer value at or below which the time score is MAX_SCORE.
- TIME_LIMIT, 600, timer value at or above which the time score is 0. Must be > GRACE.
- MAX_SCORE, 100, full score. Must be < 2**SCORE_W.
- ERR_PENALTY, 5, points deducted per mistake.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- calc_req  in  1  single-cycle request; sampled only in IDLE
- clear  in  1  synchronous clear: aborts any calculation and sets score to 0
- timer  in  TIMER_W  elapsed seconds; captured on the accepted request
- errors  in  ERR_W  mistake count; captured on the accepted request
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse when score is updated
- score  out  SCORE_W  last computed score; holds between calculations
- best_score  out  SCORE_W  best score since reset (see Optional Feature)

Behaviour:
- Reset (asynchronous): state=IDLE; score, best_score, busy and done are 0; internal registers are 0.
- NUM_W = TIMER_W+SCORE_W (18 at defaults). The divider quotient is NUM_W bits wide.
- State IDLE:
  - calc_req=1 at edge k: capture timer and errors, select the branch, and go to DIVIDE.
  - Branch selection:
    - timer<=GRACE: base=MAX_SCORE.
    - timer>=TIME_LIMIT: base=0.
    - otherwise: numerator=(timer-GRACE)*MAX_SCORE, divisor=TIME_LIMIT-GRACE.
- State DIVIDE:
  - Restoring division, NUM_W cycles, one quotient bit per edge, MSB first.
  - Runs for the full count on every branch, so latency is constant.
- State APPLY:
  - base = MAX_SCORE - quotient (divide branch only).
  - penalty = errors*ERR_PENALTY, computed at a width wide enough not to overflow.
  - score = base - penalty, saturating at 0.
  - Register score, pulse done, return to IDLE.
- Latency: the request is accepted at edge k; score and done update at edge k+NUM_W+1. done is high for exactly one cycle.
- busy is high in DIVIDE and APPLY. calc_req while busy is ignored, with no queuing.
- The division result is floored. The divide branch never yields 0 from time alone; saturation applies only via penalty.
- clear has priority over calc_req and over all states. At the edge where clear=1:
  - score=0, state=IDLE, busy=0, done=0.
  - best_score is unaffected.
- calc_req and clear in the same cycle: clear wins and the request is dropped.
- Reset mid-calculation returns every output to 0 immediately.

Optional Feature:
- Macro SCORE_BEST_EN.
- Defined: on each done, if the new score > best_score, then best_score takes the new score in the same edge. best_score is cleared only by reset.
- Undefined: best_score is tied to 0 and no comparator or register is built.

Decomposition:
- Package score_pkg holds:
  - Default constants GRACE, TIME_LIMIT, MAX_SCORE, ERR_PENALTY.
  - FSM state enum {IDLE, DIVIDE, APPLY}.
  - NUM_W derivation helper.
- One sub-module, seq_divider: parametrised unsigned restoring divider with start/done, NUM_W cycles. It is reusable by the timer/statistics blocks.

Test Plan:
- timer=30, errors=0, calc_req pulse -> busy high; done after exactly 19 edges; score=100. Repeat with timer=60 -> score=100.
- timer=330, errors=0 -> score=50. Same timer with errors=3 -> score=35.
- timer=61, errors=0 -> score=100 (floor). timer=599 -> score=1. timer=599, errors=1 -> score=0 (saturated).
- timer=600 -> score=0. timer=2047, errors=15 -> score=0. Score holds its value across 50 idle cycles.
- Second calc_req while busy -> ignored, exactly one done. clear asserted mid-DIVIDE -> score=0, busy=0, no done. Reset mid-DIVIDE -> all outputs 0.
- With SCORE_BEST_EN: run scores 50, 100, 35 -> best_score reads 50, then 100, then 100. clear leaves it at 100; reset sets it to 0. Without the macro, best_score stays 0 throughout.
